// File: rtl/barrel_shift_arb.sv
// barrel_shift_arb: round-robin arbiter in front of one shared shift/rotate
// datapath, with a single-entry registered response stage.
module barrel_shift_arb #(
  parameter int unsigned N = 8,
  parameter int unsigned R = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [R-1:0]               req_valid,
  output logic [R-1:0]               req_ready,
  input  logic [R*N-1:0]             req_data,
  input  logic [R*$clog2(N)-1:0]     req_shift,
  input  logic [R*3-1:0]             req_op,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [N-1:0]               resp_data,
  output logic [$clog2(R)-1:0]       resp_id,
  output logic                       resp_err,
  output logic [15:0]                done_cnt
);

  localparam int unsigned SW = $clog2(N);
  localparam int unsigned IW = $clog2(R);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic            found;
  logic            accept;
  logic            grant;
  logic [N-1:0]    op_data;
  logic [SW-1:0]   op_shift;
  logic [2:0]      op_code;
  logic [N-1:0]    sh_data;
  logic            sh_err;
  logic [N-1:0]    data_q;
  logic [IW-1:0]   id_q;
  logic            err_q;
  logic [15:0]     cnt_q;

  // Round-robin search starting at the priority pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < int'(R); k++) begin
      idx = ptr_q + IW'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Accept when the output slot is free or being drained this cycle.
  always_comb begin
    accept    = !rst && ((state_q == EMPTY) || resp_ready);
    grant     = accept && found;
    req_ready = grant ? (R'(1) << win) : '0;
  end

  // Shared shift datapath fed by the winner's command.
  always_comb begin
    op_data  = req_data[win*N +: N];
    op_shift = req_shift[win*SW +: SW];
    op_code  = req_op[win*3 +: 3];
    sh_data  = '0;
    sh_err   = 1'b0;
    case (op_code)
      3'd0: sh_data = op_data >> op_shift;
      3'd1: sh_data = N'($signed(op_data) >>> op_shift);
      3'd2: sh_data = op_data << op_shift;
      3'd3: sh_data = (op_data >> op_shift) | (op_data << (N - 32'(op_shift)));
      3'd4: sh_data = (op_data << op_shift) | (op_data >> (N - 32'(op_shift)));
      default: begin
        sh_data = '0;
        sh_err  = 1'b1;
      end
    endcase
  end

  // Output stage state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  // Output stage next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (grant) state_d = FULL;
      FULL:    if (resp_ready && !grant) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Response payload: load on grant, clear when drained with nothing behind it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      id_q   <= '0;
      err_q  <= 1'b0;
    end else if (grant) begin
      data_q <= sh_data;
      id_q   <= win;
      err_q  <= sh_err;
    end else if ((state_q == FULL) && resp_ready) begin
      data_q <= '0;
      id_q   <= '0;
      err_q  <= 1'b0;
    end
  end

  // Priority pointer moves past each winner.
  always_ff @(posedge clk) begin
    if (rst)        ptr_q <= '0;
    else if (grant) ptr_q <= win + IW'(1);
  end

  // Completed-response counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst)                                   cnt_q <= '0;
    else if ((state_q == FULL) && resp_ready)  cnt_q <= cnt_q + 16'd1;
  end

  assign resp_valid = (state_q == FULL);
  assign resp_data  = data_q;
  assign resp_id    = id_q;
  assign resp_err   = err_q;
  assign done_cnt   = cnt_q;

endmodule

// File: tb/tb_barrel_shift_arb.sv
// Directed self-checking bench for barrel_shift_arb (N=8, R=4).
module tb_barrel_shift_arb;

  localparam int N  = 8;
  localparam int R  = 4;
  localparam int SW = 3;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [R-1:0]    req_valid;
  logic [R-1:0]    req_ready;
  logic [R*N-1:0]  req_data;
  logic [R*SW-1:0] req_shift;
  logic [R*3-1:0]  req_op;
  logic            resp_valid;
  logic            resp_ready;
  logic [N-1:0]    resp_data;
  logic [IW-1:0]   resp_id;
  logic            resp_err;
  logic [15:0]     done_cnt;

  int checks   = 0;
  int failures = 0;

  barrel_shift_arb #(.N(N), .R(R)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_shift  (req_shift),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .resp_err   (resp_err),
    .done_cnt   (done_cnt)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [7:0] d, input logic [2:0] s, input logic [2:0] o);
    req_data[i*N +: N]   = d;
    req_shift[i*SW +: SW] = s;
    req_op[i*3 +: 3]     = o;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    req_data = '0; req_shift = '0; req_op = '0;
    tick();
    tick();
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    checks++;
    if ({resp_valid, resp_data, resp_id, resp_err} !== 12'h000) begin
      failures++; $display("FAIL reset_resp got v=%b d=%h id=%0d e=%b exp zeros", resp_valid, resp_data, resp_id, resp_err);
    end
    checks++;
    if (done_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", done_cnt); end
    rst = 1'b0;
    req_valid = '0;
    #1;
  endtask

  task automatic test_opcodes();
    logic [2:0] ops  [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [2:0] shs  [10] = '{3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    logic [7:0] dats [10] = '{8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'hB4, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96};
    logic [7:0] exps [10] = '{8'h2D, 8'hED, 8'hA0, 8'h96, 8'hA5, 8'h96, 8'h96, 8'h96, 8'h96, 8'h96};
    resp_ready = 1'b1;
    for (int v = 0; v < 10; v++) begin
      set_cmd(0, dats[v], shs[v], ops[v]);
      req_valid = 4'b0001;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin failures++; $display("FAIL op_ready[%0d] got=%b exp=0001", v, req_ready); end
      tick();
      req_valid = '0;
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== exps[v] || resp_id !== 2'd0 || resp_err !== 1'b0) begin
        failures++;
        $display("FAIL op_result[%0d] got v=%b d=%h id=%0d e=%b exp v=1 d=%h id=0 e=0",
                 v, resp_valid, resp_data, resp_id, resp_err, exps[v]);
      end
      tick();
    end
    checks++;
    if (done_cnt !== 16'd10 || resp_valid !== 1'b0) begin
      failures++; $display("FAIL op_cnt got cnt=%0d v=%b exp cnt=10 v=0", done_cnt, resp_valid);
    end
  endtask

  task automatic test_fairness();
    logic [7:0] d [4] = '{8'h11, 8'h22, 8'h44, 8'h88};
    do_reset();
    for (int i = 0; i < R; i++) set_cmd(i, d[i], 3'd0, 3'd0);
    req_valid = 4'b1111;
    resp_ready = 1'b1;
    #1;
    for (int c = 0; c < 8; c++) begin
      checks++;
      if (req_ready !== 4'(1 << (c % 4))) begin
        failures++; $display("FAIL rr_grant[%0d] got=%b exp=%b", c, req_ready, 4'(1 << (c % 4)));
      end
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'(c % 4) || resp_data !== d[c % 4]) begin
        failures++; $display("FAIL rr_resp[%0d] got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                             c, resp_valid, resp_id, resp_data, c % 4, d[c % 4]);
      end
    end
    req_valid = '0;
    tick();
    checks++;
    if (done_cnt !== 16'd8 || resp_valid !== 1'b0 || resp_data !== 8'h00 || resp_id !== 2'd0) begin
      failures++; $display("FAIL rr_drain got cnt=%0d v=%b d=%h id=%0d exp cnt=8 v=0 d=00 id=0",
                           done_cnt, resp_valid, resp_data, resp_id);
    end
  endtask

  task automatic test_backpressure();
    resp_ready = 1'b1;
    set_cmd(1, 8'h81, 3'd1, 3'd2);
    req_valid = 4'b0010;
    tick();
    set_cmd(0, 8'h55, 3'd0, 3'd0);
    set_cmd(2, 8'hF0, 3'd4, 3'd0);
    set_cmd(3, 8'h33, 3'd0, 3'd0);
    req_valid = 4'b1111;
    resp_ready = 1'b0;
    #1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (req_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready[%0d] got=%b exp=0000", c, req_ready); end
      tick();
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== 8'h02 || resp_id !== 2'd1 || resp_err !== 1'b0 || done_cnt !== 16'd8) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b d=%h id=%0d e=%b cnt=%0d exp v=1 d=02 id=1 e=0 cnt=8",
                             c, resp_valid, resp_data, resp_id, resp_err, done_cnt);
      end
    end
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL bp_release_ready got=%b exp=0100", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd2 || resp_data !== 8'h0F || done_cnt !== 16'd9) begin
      failures++; $display("FAIL bp_release got v=%b id=%0d d=%h cnt=%0d exp v=1 id=2 d=0f cnt=9",
                           resp_valid, resp_id, resp_data, done_cnt);
    end
    tick();
  endtask

  task automatic test_illegal();
    resp_ready = 1'b1;
    set_cmd(2, 8'hFF, 3'd5, 3'd6);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin failures++; $display("FAIL ill_ready got=%b exp=0100", req_ready); end
    tick();
    checks++;
    if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== 8'h00 || resp_id !== 2'd2) begin
      failures++; $display("FAIL ill_resp got v=%b e=%b d=%h id=%0d exp v=1 e=1 d=00 id=2",
                           resp_valid, resp_err, resp_data, resp_id);
    end
    set_cmd(0, 8'h77, 3'd0, 3'd0);
    set_cmd(3, 8'h3C, 3'd2, 3'd3);
    req_valid = 4'b1001;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin failures++; $display("FAIL ill_ptr got=%b exp=1000", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (resp_id !== 2'd3 || resp_data !== 8'h0F || resp_err !== 1'b0 || done_cnt !== 16'd11) begin
      failures++; $display("FAIL ill_next got id=%0d d=%h e=%b cnt=%0d exp id=3 d=0f e=0 cnt=11",
                           resp_id, resp_data, resp_err, done_cnt);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    resp_ready = 1'b1;
    set_cmd(0, 8'h11, 3'd0, 3'd0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    resp_ready = 1'b0;
    rst = 1'b1;
    req_valid = 4'b1111;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin failures++; $display("FAIL rmid_ready got=%b exp=0000", req_ready); end
    tick();
    rst = 1'b0;
    req_valid = '0;
    checks++;
    if (resp_valid !== 1'b0 || done_cnt !== 16'd0 || resp_data !== 8'h00) begin
      failures++; $display("FAIL rmid_clear got v=%b cnt=%0d d=%h exp v=0 cnt=0 d=00", resp_valid, done_cnt, resp_data);
    end
    set_cmd(1, 8'hA1, 3'd0, 3'd0);
    set_cmd(3, 8'hA3, 3'd0, 3'd0);
    req_valid = 4'b1010;
    resp_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin failures++; $display("FAIL rmid_grant got=%b exp=0010", req_ready); end
    tick();
    req_valid = '0;
    checks++;
    if (resp_valid !== 1'b1 || resp_id !== 2'd1 || resp_data !== 8'hA1 || done_cnt !== 16'd0) begin
      failures++; $display("FAIL rmid_resp got v=%b id=%0d d=%h cnt=%0d exp v=1 id=1 d=a1 cnt=0",
                           resp_valid, resp_id, resp_data, done_cnt);
    end
    tick();
    checks++;
    if (done_cnt !== 16'd1) begin failures++; $display("FAIL rmid_cnt got=%0d exp=1", done_cnt); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    resp_ready = 1'b0;
    req_data = '0; req_shift = '0; req_op = '0;
    test_reset();
    test_opcodes();
    test_fairness();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/barrel_shift_arb.md
BARREL_SHIFT_ARB -- requirements
Module: barrel_shift_arb

Interface
REQ-001 Parameter N, default 8, SHALL set the data width in bits; legal values are powers of two, N >= 4.
REQ-002 Parameter R, default 4, SHALL set the number of requesters; legal values are powers of two, R >= 2.
REQ-003 Port clk, input, 1 bit, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1 bit, SHALL be the synchronous, active-high reset.
REQ-005 Port req_valid, input, R bits: bit i asserts that requester i presents a command.
REQ-006 Port req_ready, output, R bits: bit i high means requester i's command is accepted this cycle.
REQ-007 Port req_data, input, R*N bits: requester i's operand occupies slice [i*N +: N].
REQ-008 Port req_shift, input, R*$clog2(N) bits: requester i's shift amount occupies slice [i*$clog2(N) +: $clog2(N)].
REQ-009 Port req_op, input, R*3 bits: requester i's opcode occupies slice [i*3 +: 3].
REQ-010 Port resp_valid, output, 1 bit: a result is held on resp_*.
REQ-011 Port resp_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-012 Port resp_data, output, N bits: the shifted result.
REQ-013 Port resp_id, output, $clog2(R) bits: index of the requester that owns the result.
REQ-014 Port resp_err, output, 1 bit: the opcode was illegal (5..7).
REQ-015 Port done_cnt, output, 16 bits: count of completed responses, wrapping.

Function
REQ-016 Opcodes SHALL be: 0 = logical shift right; 1 = arithmetic shift right (MSB fill); 2 = logical shift left; 3 = rotate right; 4 = rotate left. The shift amount SHALL range 0..N-1.
REQ-017 The block SHALL share one combinational shift datapath among all requesters; instantiating the team's existing barrel_shift module is permitted.
REQ-018 The output stage SHALL be a two-state FSM:
- EMPTY: resp_valid = 0.
- FULL: resp_valid = 1.
REQ-019 Acceptance SHALL be allowed in a cycle iff the state is EMPTY, or the state is FULL and resp_ready = 1.
REQ-020 When acceptance is allowed and at least one req_valid bit is high, exactly one req_ready bit SHALL be high: the round-robin winner.
- All other req_ready bits SHALL be 0.
- req_ready MAY depend combinationally on req_valid.
REQ-021 Round-robin rule:
- A priority pointer P, reset to 0, selects the highest-priority requester.
- The winner is the first requester with req_valid = 1 in the order P, P+1, ..., P+R-1 (mod R).
- After a grant to requester i, P SHALL become (i+1) mod R.
- P SHALL NOT change in cycles with no grant.
REQ-022 Latency SHALL be 1 cycle: a command accepted at edge t SHALL appear on resp_data, resp_id and resp_err after edge t, with resp_valid = 1.
REQ-023 Sustained throughput SHALL be one command per cycle while resp_ready = 1.
REQ-024 State transitions:
- EMPTY + grant -> FULL.
- FULL + resp_ready + grant -> FULL, with new contents.
- FULL + resp_ready + no grant -> EMPTY.
- FULL + !resp_ready -> FULL, with resp_* held stable.
REQ-025 An illegal opcode (5..7) SHALL still be granted and answered, with resp_err = 1 and resp_data = 0.
REQ-026 A shift amount of 0 SHALL return the operand unchanged for every legal opcode.
REQ-027 done_cnt SHALL increment by 1 on each cycle with resp_valid = 1 and resp_ready = 1, wrapping from 0xFFFF to 0x0000.
REQ-028 While resp_valid = 0, resp_data, resp_id and resp_err SHALL be 0.

Reset
REQ-029 While rst = 1:
- State = EMPTY, P = 0, done_cnt = 0.
- resp_valid = 0, resp_data = 0, resp_id = 0, resp_err = 0.
- All req_ready bits = 0.
REQ-030 A reset asserted while the state is FULL SHALL discard the held result without counting it.
REQ-031 The first grant after reset release SHALL follow REQ-021 with P = 0.

Verification
REQ-032 Opcode check (N=8, R=4), requester 0 only, data 0xB4, resp_ready = 1:
- op0 shift 2 -> 0x2D
- op1 shift 2 -> 0xED
- op2 shift 3 -> 0xA0
- op3 shift 3 -> 0x96
- op4 shift 3 -> 0xA5
- In each case resp_id = 0 and resp_err = 0, one cycle after acceptance.
REQ-033 Fairness: all four req_valid bits held high with resp_ready = 1 -> grants 0, 1, 2, 3, 0, ... on consecutive cycles; resp_id follows one cycle later; done_cnt = 8 after 8 responses.
REQ-034 Backpressure: resp_ready = 0 for 5 cycles while FULL -> all req_ready bits are 0 and resp_* is held stable; resp_ready = 1 on the next cycle -> the held result is consumed and the next command is granted in the same cycle.
REQ-035 Illegal opcode: op = 6 on requester 2 -> resp_err = 1, resp_data = 0x00, resp_id = 2; P becomes 3.
REQ-036 Reset mid-operation: rst pulsed for 1 cycle while FULL with resp_ready = 0 -> resp_valid = 0 and done_cnt = 0 on the next cycle; the next simultaneous request from requesters 1 and 3 grants requester 1.
